// File: rtl/present_sbox_layer.sv
// Multi-cycle PRESENT substitution layer: LANES S-boxes applied per cycle to a rotating state.
// Optional macro SBOX_INV_EN compiles in the inverse S-box selected by in_inv.
module present_sbox_layer #(
    parameter int unsigned STATE_W = 64,
    parameter int unsigned LANES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data
);

    localparam int unsigned CHUNK_W = 4 * LANES;
    localparam int unsigned NSTEP   = STATE_W / CHUNK_W;
    localparam int unsigned CNT_W   = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [STATE_W-1:0] work, work_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CHUNK_W-1:0] sub_chunk;
    logic [STATE_W-1:0] stepped;
    logic               in_ready_d, out_valid_d;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        case (x)
            4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;
            4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
            4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;
            4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
            4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;
            4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
            4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;
            4'hE: sbox_fwd = 4'h1;  default: sbox_fwd = 4'h2;
        endcase
    endfunction

`ifdef SBOX_INV_EN
    logic mode, mode_d;

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;
            4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;
            4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;
            4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;
            4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    // Substitute the least-significant LANES nibbles with the latched mode
    always_comb begin
        sub_chunk = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            sub_chunk[4*l +: 4] = mode ? sbox_inv(work[4*l +: 4]) : sbox_fwd(work[4*l +: 4]);
        end
    end

    always_comb begin
        mode_d = mode;
        if (state == IDLE && in_valid) begin
            mode_d = in_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else begin
            mode <= mode_d;
        end
    end
`else
    // Forward-only build: in_inv stays on the port list but has no effect
    logic unused_inv;
    assign unused_inv = in_inv;

    always_comb begin
        sub_chunk = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            sub_chunk[4*l +: 4] = sbox_fwd(work[4*l +: 4]);
        end
    end
`endif

    // Rotate right by one chunk with the substituted chunk landing on top
    assign stepped = STATE_W'({sub_chunk, work} >> CHUNK_W);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state;
        work_d  = work;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = stepped;
                cnt_d  = CNT_W'(cnt + 1'b1);
                if (cnt == CNT_W'(NSTEP - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            work      <= work_d;
            cnt       <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    assign out_data = work;

endmodule

// File: tb/tb_present_sbox_layer.sv
// Self-checking bench for present_sbox_layer: default, LANES=16 and LANES=1 instances
// compared against a nibble-table reference model.
`timescale 1ns/1ps
module tb_present_sbox_layer;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

`ifdef SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    localparam logic [3:0] INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    // Default instance
    logic        in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [63:0] in_data, out_data;

    present_sbox_layer #(.STATE_W(64), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // LANES=16 and LANES=1 instances share their inputs
    logic        a_in_valid, a_in_inv, a_out_ready;
    logic [63:0] a_in_data;
    logic        l16_in_ready, l16_out_valid, l1_in_ready, l1_out_valid;
    logic [63:0] l16_out_data, l1_out_data;

    present_sbox_layer #(.STATE_W(64), .LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(l16_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
        .out_valid(l16_out_valid), .out_ready(a_out_ready), .out_data(l16_out_data)
    );

    present_sbox_layer #(.STATE_W(64), .LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(l1_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
        .out_valid(l1_out_valid), .out_ready(a_out_ready), .out_data(l1_out_data)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] model(input logic [63:0] d, input bit inv);
        logic [63:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            nib = d[4*i +: 4];
            r[4*i +: 4] = (inv && INV_EN) ? INV[nib] : FWD[nib];
        end
        return r;
    endfunction

    // One transaction on the default instance; inputs are scrambled after acceptance
    task automatic main_txn(input logic [63:0] d, input bit inv,
                            output logic [63:0] res, output int lat);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_data   = d;
        in_inv    = inv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_data = {$urandom, $urandom};
            in_inv  = ~in_inv;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = out_data;
    endtask

    task automatic aux_txn(input logic [63:0] d, input bit inv,
                           output logic [63:0] r16, output int lat16,
                           output logic [63:0] r1, output int lat1);
        int  guard = 0;
        int  lat;
        bit  done16, done1;
        while (!(l16_in_ready && l1_in_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        a_in_data   = d;
        a_in_inv    = inv;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 0; lat16 = -1; lat1 = -1; done16 = 1'b0; done1 = 1'b0;
        r16 = 'x; r1 = 'x;
        while (!(done16 && done1) && lat < 100) begin
            if (!done16 && l16_out_valid) begin
                done16 = 1'b1; lat16 = lat; r16 = l16_out_data;
            end
            if (!done1 && l1_out_valid) begin
                done1 = 1'b1; lat1 = lat; r1 = l1_out_data;
            end
            if (!(done16 && done1)) begin
                a_in_data = {$urandom, $urandom};
                a_in_inv  = ~a_in_inv;
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; in_data = 64'hFFFF_0000_FFFF_0000; in_inv = 1'b0; out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_data = '0; a_in_inv = 1'b0; a_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b valid=%b data=%h need 1 0 0",
                     in_ready, out_valid, out_data);
        end
        in_valid = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
                failures++;
                $display("FAIL post_reset_idle: got ready=%b valid=%b data=%h need 1 0 0",
                         in_ready, out_valid, out_data);
            end
        end
    endtask

    task automatic test_known_vectors();
        logic [63:0] res, exp;
        int lat;
        main_txn(64'h0123456789ABCDEF, 1'b0, res, lat);
        checks++;
        if (res !== 64'hC56B90AD3EF84712) begin
            failures++;
            $display("FAIL fwd_vector: got %h need %h", res, 64'hC56B90AD3EF84712);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL fwd_latency: got %0d need 4", lat);
        end
        exp = INV_EN ? 64'h0123456789ABCDEF : model(64'hC56B90AD3EF84712, 1'b0);
        main_txn(64'hC56B90AD3EF84712, 1'b1, res, lat);
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL inv_vector: got %h need %h", res, exp);
        end
        exp = INV_EN ? 64'h5555555555555555 : 64'hCCCCCCCCCCCCCCCC;
        main_txn(64'h0, 1'b1, res, lat);
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL inv_zero: got %h need %h", res, exp);
        end
    endtask

    task automatic test_random();
        logic [63:0] d, res, exp;
        bit inv;
        int lat;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d   = {$urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            exp = model(d, inv);
            main_txn(d, inv, res, lat);
            checks++;
            if (res !== exp || lat !== 4) begin
                failures++;
                $display("FAIL random_%0d: got %h lat %0d need %h lat 4 (in %h inv %b)",
                         n, res, lat, exp, d, inv);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, exp;
        int lat = 0;
        int guard = 0;
        d   = {$urandom, $urandom};
        exp = model(d, 1'b0);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_data = d; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: got valid=%b data=%h ready=%b need 1 %h 0",
                         c, out_valid, out_data, in_ready, exp);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got ready=%b valid=%b need 1 0",
                     in_ready, out_valid);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== exp) begin
            failures++;
            $display("FAIL no_hidden_accept: got valid=%b data=%h need 0 %h",
                     out_valid, out_data, exp);
        end
    endtask

    task automatic test_mode_latching();
        logic [63:0] d, res, exp;
        int lat;
        for (int m = 0; m < 2; m++) begin
            d   = {$urandom, $urandom};
            exp = model(d, m[0]);
            main_txn(d, m[0], res, lat);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL mode_latch_%0d: got %h need %h", m, res, exp);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [63:0] res;
        int lat;
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_data = {$urandom, $urandom}; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid_busy: got ready=%b valid=%b data=%h need 1 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard: got valid=%b ready=%b need 0 1", out_valid, in_ready);
        end
        main_txn(64'hFFFFFFFFFFFFFFFF, 1'b0, res, lat);
        checks++;
        if (res !== 64'h2222222222222222 || lat !== 4) begin
            failures++;
            $display("FAIL after_reset_txn: got %h lat %0d need 2222222222222222 lat 4", res, lat);
        end
    endtask

    task automatic test_lanes();
        logic [63:0] r16, r1, d, exp;
        int lat16, lat1;
        bit inv;
        aux_txn(64'h0, 1'b0, r16, lat16, r1, lat1);
        checks++;
        if (r16 !== 64'hCCCCCCCCCCCCCCCC || lat16 !== 1) begin
            failures++;
            $display("FAIL lanes16_zero: got %h lat %0d need cccccccccccccccc lat 1", r16, lat16);
        end
        checks++;
        if (r1 !== 64'hCCCCCCCCCCCCCCCC || lat1 !== 16) begin
            failures++;
            $display("FAIL lanes1_zero: got %h lat %0d need cccccccccccccccc lat 16", r1, lat1);
        end
        for (int n = 0; n < 4; n++) begin
            d   = {$urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            exp = model(d, inv);
            aux_txn(d, inv, r16, lat16, r1, lat1);
            checks++;
            if (r16 !== exp || lat16 !== 1) begin
                failures++;
                $display("FAIL lanes16_rand_%0d: got %h lat %0d need %h lat 1", n, r16, lat16, exp);
            end
            checks++;
            if (r1 !== exp || lat1 !== 16) begin
                failures++;
                $display("FAIL lanes1_rand_%0d: got %h lat %0d need %h lat 16", n, r1, lat1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_mode_latching();
        test_reset_mid_busy();
        test_lanes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
